// File: rtl/seq_divider_if.sv
// Start/done handshake bundle for the sequential restoring divider.
// The master side issues operands and a start request; the slave side
// (the divider) reports busy, the done pulse and the held results.
interface seq_divider_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start,
        output dividend,
        output divisor,
        input  busy,
        input  done,
        input  quotient,
        input  remainder,
        input  div_by_zero
    );

    modport slave (
        input  start,
        input  dividend,
        input  divisor,
        output busy,
        output done,
        output quotient,
        output remainder,
        output div_by_zero
    );
endinterface

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider.
// One trial subtraction per clock in RUN; results, done and busy are all
// registered. The result registers are loaded on the edge that leaves DONE,
// so done, quotient, remainder and div_by_zero appear together in the cycle
// after that edge, which is also the first IDLE cycle able to accept the
// next start (issue interval WIDTH+2 for a normal divide).
module seq_divider #(
    parameter int WIDTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    seq_divider_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [CW-1:0]    r_count;
    logic [WIDTH:0]   r_rem;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_divisor;
    logic             r_dbz;

    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_quotient;
    logic [WIDTH-1:0] r_remainder;
    logic             r_div_by_zero;

    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_trial;
    logic             w_last_iter;

    // Shift the next dividend bit into the partial remainder and try the subtraction;
    // bit WIDTH of the trial is the borrow.
    assign w_shift     = {r_rem[WIDTH-1:0], r_q[WIDTH-1]};
    assign w_trial     = w_shift - {1'b0, r_divisor};
    assign w_last_iter = (r_count == CW'(WIDTH - 1));

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next-state logic; a zero divisor skips RUN entirely.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    if (bus.divisor == '0) begin
                        w_next_state = ST_DONE;
                    end else begin
                        w_next_state = ST_RUN;
                    end
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (w_last_iter) begin
                    w_next_state = ST_DONE;
                end else begin
                    w_next_state = ST_RUN;
                end
            end
            ST_DONE: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Operand capture in IDLE and one restoring iteration per RUN cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count   <= '0;
            r_rem     <= '0;
            r_q       <= '0;
            r_divisor <= '0;
            r_dbz     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_count   <= '0;
                        r_rem     <= '0;
                        r_q       <= bus.dividend;
                        r_divisor <= bus.divisor;
                        r_dbz     <= (bus.divisor == '0);
                    end
                end
                ST_RUN: begin
                    if (!w_trial[WIDTH]) begin
                        r_rem <= w_trial;
                        r_q   <= {r_q[WIDTH-2:0], 1'b1};
                    end else begin
                        r_rem <= w_shift;
                        r_q   <= {r_q[WIDTH-2:0], 1'b0};
                    end
                    r_count <= r_count + CW'(1);
                end
                default: begin
                    r_count <= r_count;
                end
            endcase
        end
    end

    // Registered handshake outputs and result capture as DONE is left.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_quotient    <= '0;
            r_remainder   <= '0;
            r_div_by_zero <= 1'b0;
        end else begin
            r_busy <= (w_next_state != ST_IDLE);
            r_done <= (r_state == ST_DONE);
            if (r_state == ST_DONE) begin
                if (r_dbz) begin
                    // Q still holds the captured dividend on the zero-divisor path.
                    r_quotient  <= '1;
                    r_remainder <= r_q;
                end else begin
                    r_quotient  <= r_q;
                    r_remainder <= r_rem[WIDTH-1:0];
                end
                r_div_by_zero <= r_dbz;
            end else begin
                r_quotient    <= r_quotient;
                r_remainder   <= r_remainder;
                r_div_by_zero <= r_div_by_zero;
            end
        end
    end

    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.quotient    = r_quotient;
    assign bus.remainder   = r_remainder;
    assign bus.div_by_zero = r_div_by_zero;
endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider (WIDTH=4): directed vectors push the
// expected result and done cycle; a negedge monitor pops and compares.
module tb_seq_divider;
    localparam int W = 4;

    typedef struct packed {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        logic [31:0]  due;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [31:0] cyc;
    int          checks;
    int          errors;
    exp_t        sb[$];

    logic [W-1:0] last_q;
    logic [W-1:0] last_r;
    logic         last_dz;
    logic         prev_done;

    seq_divider_if #(.WIDTH(W)) bus ();

    seq_divider #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge counter: at a negedge, cyc equals the index of the last rising edge.
    initial cyc = 32'd0;
    always @(posedge clk) cyc <= cyc + 32'd1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compare each done pulse against the scoreboard head, and check
    // that outputs hold between pulses and done never lasts two cycles.
    always @(negedge clk) begin
        if (!rst_n) begin
            last_q    = '0;
            last_r    = '0;
            last_dz   = 1'b0;
            prev_done = 1'b0;
        end else begin
            if (bus.done) begin
                chk("done_width", 32'(prev_done), 32'd0);
                if (sb.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("quotient", 32'(bus.quotient), 32'(e.q));
                    chk("remainder", 32'(bus.remainder), 32'(e.r));
                    chk("div_by_zero", 32'(bus.div_by_zero), 32'(e.dz));
                    chk("latency", cyc, e.due);
                    last_q  = e.q;
                    last_r  = e.r;
                    last_dz = e.dz;
                end
            end else begin
                chk("hold", {23'd0, bus.quotient, bus.remainder, bus.div_by_zero},
                    {23'd0, last_q, last_r, last_dz});
                if (sb.size() > 0 && cyc > sb[0].due) begin
                    chk("done_timeout", cyc, sb[0].due);
                    void'(sb.pop_front());
                end
            end
            prev_done = bus.done;
        end
    end

    // Wait for an idle slot, present operands for one edge, then scramble the inputs.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] eq, input logic [W-1:0] er, input logic edz);
        int   n;
        exp_t e;
        n = 0;
        @(negedge clk);
        while (bus.busy && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (bus.busy) chk("busy_timeout", 32'd1, 32'd0);
        #1;
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        e.q   = eq;
        e.r   = er;
        e.dz  = edz;
        e.due = cyc + 32'd1 + ((b == '0) ? 32'd1 : 32'(W + 1));
        sb.push_back(e);
        @(posedge clk);
        #1;
        bus.start    = 1'b0;
        bus.dividend = ~a;
        bus.divisor  = ~b;
    endtask

    task automatic pulse_ignored(input logic [W-1:0] a, input logic [W-1:0] b);
        #1;
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    initial begin
        int n;
        checks       = 0;
        errors       = 0;
        rst_n        = 1'b0;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_quotient", 32'(bus.quotient), 32'd0);
        chk("rst_remainder", 32'(bus.remainder), 32'd0);
        chk("rst_dbz", 32'(bus.div_by_zero), 32'd0);
        #2 rst_n = 1'b1;

        // Basic divides.
        issue(4'd13, 4'd3, 4'd4, 4'd1, 1'b0);
        issue(4'd2, 4'd9, 4'd0, 4'd2, 1'b0);
        issue(4'd15, 4'd1, 4'd15, 4'd0, 1'b0);
        // Divide by zero, then a normal divide clears the flag.
        issue(4'd7, 4'd0, 4'hF, 4'd7, 1'b1);
        issue(4'd8, 4'd2, 4'd4, 4'd0, 1'b0);

        // Starts during RUN are ignored.
        issue(4'd14, 4'd4, 4'd3, 4'd2, 1'b0);
        @(negedge clk);
        pulse_ignored(4'd9, 4'd3);
        @(negedge clk);
        @(negedge clk);
        pulse_ignored(4'd9, 4'd3);

        // Reset in the middle of a divide aborts it with no done pulse.
        issue(4'd11, 4'd2, 4'd5, 4'd1, 1'b0);
        @(negedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        sb.delete();
        #1;
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_done", 32'(bus.done), 32'd0);
        chk("abort_quotient", 32'(bus.quotient), 32'd0);
        chk("abort_remainder", 32'(bus.remainder), 32'd0);
        chk("abort_dbz", 32'(bus.div_by_zero), 32'd0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        issue(4'd11, 4'd2, 4'd5, 4'd1, 1'b0);

        // Every operand pair at minimum issue interval.
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                if (b == 0) begin
                    issue(4'(a), 4'd0, 4'hF, 4'(a), 1'b1);
                end else begin
                    issue(4'(a), 4'(b), 4'(a / b), 4'(a % b), 1'b0);
                end
            end
        end

        n = 0;
        while (sb.size() != 0 && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 32'(sb.size()), 32'd0);
        repeat (10) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
